// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: a main register that drives the outputs directly, plus a
// one-entry skid buffer so that in_ready comes from a flop instead of from out_ready.
module pipe_stage_reg #(
  parameter int          PAYLOAD_W = 32,
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_PC    = 32'h0000_4180
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_pc,
  input  logic [31:0]          in_instr,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_instr,
  output logic [PAYLOAD_W-1:0] out_payload,
  input  logic                 flush,
  input  logic                 req,
  output logic [15:0]          stall_cnt
);

  // Handshake: an entry moves across a port on a rising edge where valid && ready are
  // both high. A valid entry stays stable until it is taken; ready never depends on valid.
  localparam logic [31:0] NOP_INSTR = 32'h0;

  logic                 m_valid_q, m_valid_d;
  logic [31:0]          m_pc_q, m_pc_d;
  logic [31:0]          m_instr_q, m_instr_d;
  logic [PAYLOAD_W-1:0] m_payload_q, m_payload_d;

  logic                 s_valid_q, s_valid_d;
  logic [31:0]          s_pc_q, s_pc_d;
  logic [31:0]          s_instr_q, s_instr_d;
  logic [PAYLOAD_W-1:0] s_payload_q, s_payload_d;

  logic [15:0]          stall_cnt_q, stall_cnt_d;

  logic accept;
  logic drain;

  assign in_ready = !s_valid_q;
  assign accept   = in_valid && in_ready;
  assign drain    = m_valid_q && out_ready;

  always_comb begin
    m_valid_d   = m_valid_q;
    m_pc_d      = m_pc_q;
    m_instr_d   = m_instr_q;
    m_payload_d = m_payload_q;
    s_valid_d   = s_valid_q;
    s_pc_d      = s_pc_q;
    s_instr_d   = s_instr_q;
    s_payload_d = s_payload_q;

    if (req) begin
      m_valid_d   = 1'b1;
      m_pc_d      = EXC_PC;
      m_instr_d   = NOP_INSTR;
      m_payload_d = '0;
      s_valid_d   = 1'b0;
    end else if (flush) begin
      // The bubble keeps its pc so downstream still sees where the pipeline was.
      m_valid_d   = 1'b0;
      m_instr_d   = NOP_INSTR;
      m_payload_d = '0;
      s_valid_d   = 1'b0;
    end else if (!m_valid_q || drain) begin
      if (s_valid_q) begin
        m_valid_d   = 1'b1;
        m_pc_d      = s_pc_q;
        m_instr_d   = s_instr_q;
        m_payload_d = s_payload_q;
        s_valid_d   = 1'b0;
      end else if (accept) begin
        m_valid_d   = 1'b1;
        m_pc_d      = in_pc;
        m_instr_d   = in_instr;
        m_payload_d = in_payload;
      end else begin
        m_valid_d   = 1'b0;
        m_instr_d   = NOP_INSTR;
        m_payload_d = '0;
      end
    end else if (accept) begin
      s_valid_d   = 1'b1;
      s_pc_d      = in_pc;
      s_instr_d   = in_instr;
      s_payload_d = in_payload;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q   <= 1'b0;
      m_pc_q      <= PC_RESET;
      m_instr_q   <= NOP_INSTR;
      m_payload_q <= '0;
      s_valid_q   <= 1'b0;
      s_pc_q      <= '0;
      s_instr_q   <= '0;
      s_payload_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_pc_q      <= m_pc_d;
      m_instr_q   <= m_instr_d;
      m_payload_q <= m_payload_d;
      s_valid_q   <= s_valid_d;
      s_pc_q      <= s_pc_d;
      s_instr_q   <= s_instr_d;
      s_payload_q <= s_payload_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid   = m_valid_q;
  assign out_pc      = m_pc_q;
  assign out_instr   = m_instr_q;
  assign out_payload = m_payload_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a two-deep in-order queue model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pipe_stage_reg;

  localparam int          PW       = 32;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
  localparam int          ENT_W    = 64 + PW;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic [PW-1:0] in_payload;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic [PW-1:0] out_payload;
  logic          flush;
  logic          req;
  logic [15:0]   stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(
    .PAYLOAD_W(PW),
    .PC_RESET (PC_RESET),
    .EXC_PC   (EXC_PC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .in_payload (in_payload),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_payload(out_payload),
    .flush      (flush),
    .req        (req),
    .stall_cnt  (stall_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model: an in-order queue holding at most two entries ----------------
  logic [ENT_W-1:0] exp_q[$];
  logic [31:0]      mdl_pc;
  int               mdl_stall;
  bit               mdl_live = 1'b0;

  always @(posedge clk) begin
    bit               rdy;
    bit               acc;
    bit               drn;
    logic [ENT_W-1:0] head;
    if (reset) begin
      exp_q.delete();
      mdl_pc    = PC_RESET;
      mdl_stall = 0;
      mdl_live  = 1'b1;
    end else if (mdl_live) begin
      rdy = (exp_q.size() < 2);
      acc = in_valid && rdy;
      drn = (exp_q.size() > 0) && out_ready;
      if ((exp_q.size() > 0) && !out_ready && (mdl_stall < 65535)) mdl_stall++;
      if (req) begin
        exp_q.delete();
        exp_q.push_back({EXC_PC, 32'h0, {PW{1'b0}}});
      end else if (flush) begin
        exp_q.delete();
      end else begin
        if (drn) void'(exp_q.pop_front());
        if (acc) exp_q.push_back({in_pc, in_instr, in_payload});
      end
      if (exp_q.size() > 0) begin
        head   = exp_q[0];
        mdl_pc = head[PW+32 +: 32];
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [ENT_W-1:0] head;
    if (mdl_live) begin
      chk("cyc_out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() > 0});
      chk("cyc_in_ready", {31'b0, in_ready}, {31'b0, exp_q.size() < 2});
      chk("cyc_out_pc", out_pc, mdl_pc);
      chk("cyc_stall_cnt", {16'b0, stall_cnt}, mdl_stall);
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        chk("cyc_out_instr", out_instr, head[PW +: 32]);
        chk("cyc_out_payload", out_payload, head[PW-1:0]);
      end else begin
        chk("cyc_bubble_instr", out_instr, 32'h0);
        chk("cyc_bubble_payload", out_payload, 32'h0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; drives one cycle of inputs and returns at the next falling edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                      input logic ordy, input logic fl, input logic rq);
    in_valid   = v;
    in_pc      = pc;
    in_instr   = instr;
    in_payload = pc ^ 32'hA5A5_0000;
    out_ready  = ordy;
    flush      = fl;
    req        = rq;
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 32'h0, ordy, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(1'b0);
    reset = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int hits;
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; in_payload = '0;
    out_ready = 1'b0; flush = 1'b0; req = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'h0000_3000);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_payload", out_payload, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
    reset = 1'b0;

    // single entry, one-cycle latency
    step(1'b1, 32'h3000, 32'h3C01_0001, 1'b1, 1'b0, 1'b0);
    chk("lat_out_valid", {31'b0, out_valid}, 32'd1);
    chk("lat_out_pc", out_pc, 32'h3000);
    chk("lat_out_instr", out_instr, 32'h3C01_0001);
    chk("lat_out_payload", out_payload, 32'hA5A5_3000);
    idle(1'b1);
    chk("empty_out_valid", {31'b0, out_valid}, 32'd0);
    chk("empty_pc_kept", out_pc, 32'h3000);
    chk("empty_instr_nop", out_instr, 32'h0);

    // skid buffer fills under back-pressure, then drains in order
    step(1'b1, 32'h3004, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3008, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    chk("skid_in_ready_low", {31'b0, in_ready}, 32'd0);
    chk("skid_head_pc", out_pc, 32'h3004);
    step(1'b1, 32'h300C, 32'h0000_000C, 1'b1, 1'b0, 1'b0);
    chk("skid_second_pc", out_pc, 32'h3008);
    chk("skid_in_ready_back", {31'b0, in_ready}, 32'd1);
    idle(1'b1);
    chk("skid_drained", {31'b0, out_valid}, 32'd0);

    // stall counter: 3 cycles, unaffected by flush/req, then saturation
    do_reset();
    step(1'b1, 32'h3010, 32'h0000_0010, 1'b0, 1'b0, 1'b0);
    repeat (3) idle(1'b0);
    chk("stall_three", {16'b0, stall_cnt}, 32'd3);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("stall_after_flush", {16'b0, stall_cnt}, 32'd3);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("stall_after_req", {16'b0, stall_cnt}, 32'd3);
    repeat (65532) idle(1'b0);
    chk("stall_at_max", {16'b0, stall_cnt}, 32'h0000_FFFF);
    repeat (5) idle(1'b0);
    chk("stall_saturated", {16'b0, stall_cnt}, 32'h0000_FFFF);

    // flush with M and S full and a new input offered
    do_reset();
    step(1'b1, 32'h3020, 32'h0000_0020, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3024, 32'h0000_0024, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3028, 32'h0000_0028, 1'b0, 1'b1, 1'b0);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_out_instr", out_instr, 32'h0);
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    hits = 0;
    repeat (4) begin
      idle(1'b1);
      if (out_valid && (out_pc inside {32'h3020, 32'h3024, 32'h3028})) hits++;
    end
    chk("flush_no_reemit", hits, 32'd0);

    // flush discards an input accepted in the same cycle
    step(1'b1, 32'h3030, 32'h0000_0030, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h3034, 32'h0000_0034, 1'b1, 1'b1, 1'b0);
    chk("flush_accept_dropped", {31'b0, out_valid}, 32'd0);
    chk("flush_pc_kept", out_pc, 32'h3030);

    // req beats flush and kills concurrent input
    step(1'b1, 32'h3040, 32'h0000_0040, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3044, 32'h0000_0044, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3048, 32'h0000_0048, 1'b0, 1'b1, 1'b1);
    chk("req_out_valid", {31'b0, out_valid}, 32'd1);
    chk("req_out_pc", out_pc, 32'h4180);
    chk("req_out_instr", out_instr, 32'h0);
    chk("req_out_payload", out_payload, 32'h0);
    chk("req_in_ready", {31'b0, in_ready}, 32'd1);
    idle(1'b1);
    chk("req_consumed", {31'b0, out_valid}, 32'd0);

    // reset beats req, and discards a full stage mid-stall
    step(1'b1, 32'h3050, 32'h0000_0050, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3054, 32'h0000_0054, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b1, 32'h3058, 32'h0000_0058, 1'b0, 1'b1, 1'b1);
    reset = 1'b0;
    chk("rstreq_out_pc", out_pc, 32'h3000);
    chk("rstreq_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rstreq_in_ready", {31'b0, in_ready}, 32'd1);
    idle(1'b1);
    chk("rstreq_nothing_left", {31'b0, out_valid}, 32'd0);

    // mixed traffic table: bit i of each pattern drives cycle i
    begin
      logic [23:0] v_pat;
      logic [23:0] r_pat;
      logic [31:0] pc;
      v_pat = 24'b1101_1111_0110_1011_1110_0111;
      r_pat = 24'b1011_0011_1101_1000_0111_1101;
      pc    = 32'h3100;
      for (int i = 0; i < 24; i++) begin
        step(v_pat[i], pc, pc + 32'h1000_0000, r_pat[i], 1'b0, 1'b0);
        if (v_pat[i] && in_ready) pc = pc + 32'd4;
      end
      repeat (4) idle(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
